byte_unstriping: RTL and testbench

// - Receive-side counterpart of the 4-lane byte striper: captures one striped word (4 lane bytes
//   + per-lane valids) and re-serializes it into a single byte stream, lane 0 first, 1 byte/clk.
// - Sits between the lane receivers and the byte-stream consumer on the clk1Mhz domain.
// - Sustains full rate: a new word may be accepted every 4 cycles with no output gap.

---
 rtl/byte_striping_pkg.sv | 15 +
 rtl/unstriping_lane_mux.sv | 21 ++
 rtl/byte_unstriping.sv | 112 +++++++++++
 tb/tb_byte_unstriping.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/byte_striping_pkg.sv
// Shared definitions for the 4-lane byte striper and unstriper.
// Holds lane geometry, the counter width derived from it and the
// serializer state encoding.
package byte_striping_pkg;

  localparam int LANE_W  = 8;
  localparam int N_LANES = 4;
  localparam int CNT_W   = $clog2(N_LANES);

  typedef enum logic {
    IDLE = 1'b0,
    SER  = 1'b1
  } state_t;

endpackage

// File: rtl/unstriping_lane_mux.sv
// N_LANES:1 selector over the held word.
// Ports:
//   lanes    - held lane bytes, index 0 = lane 0
//   lane_vld - held per-lane valids
//   sel      - lane to present
//   data     - selected lane byte
//   vld      - selected lane valid
module unstriping_lane_mux
  import byte_striping_pkg::*;
(
  input  logic [N_LANES-1:0][LANE_W-1:0] lanes,
  input  logic [N_LANES-1:0]             lane_vld,
  input  logic [CNT_W-1:0]               sel,
  output logic [LANE_W-1:0]              data,
  output logic                           vld
);

  assign data = lanes[sel];
  assign vld  = lane_vld[sel];

endmodule

// File: rtl/byte_unstriping.sv
// Re-serializes one striped 4-lane word into a byte stream, lane 0 first,
// one byte per clock. A new word can be taken on the cycle the last lane
// of the previous word is emitted, so back-to-back words leave no gap.
//
// state | meaning
// IDLE  | no word in flight, ready for a word
// SER   | emitting lane cnt of the held word
//
// Ports:
//   clk1Mhz            - clock, all state on posedge
//   reset              - synchronous, active-high
//   stripedLane0..3    - incoming lane bytes
//   lane0VLD..lane3VLD - per-lane valids, sampled with the word
//   stripedVLD         - word strobe
//   inReady            - combinational: a strobed word is taken this edge
//   byteUnstripingOUT  - registered output byte
//   byteUnstripingVLD  - registered output byte valid
//   laneIdx            - registered lane index of the output byte
//   overflow           - sticky: a strobed word was dropped
module byte_unstriping
  import byte_striping_pkg::*;
(
  input  logic              clk1Mhz,
  input  logic              reset,
  input  logic [LANE_W-1:0] stripedLane0,
  input  logic [LANE_W-1:0] stripedLane1,
  input  logic [LANE_W-1:0] stripedLane2,
  input  logic [LANE_W-1:0] stripedLane3,
  input  logic              lane0VLD,
  input  logic              lane1VLD,
  input  logic              lane2VLD,
  input  logic              lane3VLD,
  input  logic              stripedVLD,
  output logic              inReady,
  output logic [LANE_W-1:0] byteUnstripingOUT,
  output logic              byteUnstripingVLD,
  output logic [CNT_W-1:0]  laneIdx,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_LANES - 1);

  state_t                         state_q;
  state_t                         state_d;
  logic [CNT_W-1:0]               cnt;
  logic [N_LANES-1:0][LANE_W-1:0] hold;
  logic [N_LANES-1:0]             hold_vld;
  logic [LANE_W-1:0]              mux_data;
  logic                           mux_vld;
  logic                           accept;

  unstriping_lane_mux u_mux (
    .lanes    (hold),
    .lane_vld (hold_vld),
    .sel      (cnt),
    .data     (mux_data),
    .vld      (mux_vld)
  );

  assign accept = stripedVLD & inReady;

  always_comb begin
    inReady = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        inReady = 1'b1;
        if (accept) state_d = SER;
      end
      SER: begin
        // The edge that emits the last lane can take the next word.
        if (cnt == LAST) begin
          inReady = 1'b1;
          state_d = accept ? SER : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1Mhz) begin
    if (reset) begin
      state_q           <= IDLE;
      cnt               <= '0;
      hold              <= '0;
      hold_vld          <= '0;
      byteUnstripingOUT <= '0;
      byteUnstripingVLD <= 1'b0;
      laneIdx           <= '0;
      overflow          <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hold     <= {stripedLane3, stripedLane2, stripedLane1, stripedLane0};
        hold_vld <= {lane3VLD, lane2VLD, lane1VLD, lane0VLD};
      end
      if (stripedVLD && !inReady) overflow <= 1'b1;
      if (state_q == SER) begin
        // Reads the pre-edge hold, so lane 3 of the old word is emitted
        // even when a new word is captured on the same edge.
        byteUnstripingOUT <= mux_data;
        byteUnstripingVLD <= mux_vld;
        laneIdx           <= cnt;
        cnt               <= cnt + 1'b1;
      end else begin
        byteUnstripingVLD <= 1'b0;
        cnt               <= '0;
      end
    end
  end

endmodule

// File: tb/tb_byte_unstriping.sv
// Scoreboard bench for byte_unstriping. The driver decides from a timing
// model whether each strobed word is taken and pushes the four expected
// output slots, stamped with the cycle they must appear; the monitor pops
// and compares independently on every falling edge.
module tb_byte_unstriping;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] l0 = '0, l1 = '0, l2 = '0, l3 = '0;
  logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
  logic       strobe = 1'b1;
  logic       in_ready;
  logic [7:0] dout;
  logic       dvld;
  logic [1:0] lane_idx;
  logic       ovf;

  byte_unstriping dut (
    .clk1Mhz           (clk),
    .reset             (reset),
    .stripedLane0      (l0),
    .stripedLane1      (l1),
    .stripedLane2      (l2),
    .stripedLane3      (l3),
    .lane0VLD          (v0),
    .lane1VLD          (v1),
    .lane2VLD          (v2),
    .lane3VLD          (v3),
    .stripedVLD        (strobe),
    .inReady           (in_ready),
    .byteUnstripingOUT (dout),
    .byteUnstripingVLD (dvld),
    .laneIdx           (lane_idx),
    .overflow          (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         stamp;
    logic       vld;
    logic [7:0] data;
    logic [1:0] lane;
  } slot_t;

  slot_t q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    last_acc = -100;
  bit    exp_ovf = 1'b0;
  bit    mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus plus the reference decision for the coming edge.
  task automatic step(input bit s, input logic [3:0][7:0] b, input logic [3:0] v, input bit r);
    int  edge_no;
    bit  ready_m;
    slot_t e;
    @(negedge clk);
    #2;
    reset = r; strobe = s;
    l0 = b[0]; l1 = b[1]; l2 = b[2]; l3 = b[3];
    v0 = v[0]; v1 = v[1]; v2 = v[2]; v3 = v[3];
    edge_no = cyc + 1;
    // A word occupies the output for 4 cycles; the next one may be taken
    // on the edge that emits the last byte of the previous one.
    ready_m = (edge_no >= last_acc + 4);
    if (r) begin
      q.delete();
      last_acc = -100;
      exp_ovf  = 1'b0;
    end else begin
      #1;
      chk("in_ready", in_ready, ready_m);
      if (s && ready_m) begin
        last_acc = edge_no;
        for (int i = 0; i < 4; i++) begin
          e.stamp = edge_no + 1 + i;
          e.vld   = v[i];
          e.data  = b[i];
          e.lane  = 2'(i);
          q.push_back(e);
        end
      end else if (s) begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  initial begin : monitor
    slot_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (q.size() > 0 && q[0].stamp == cyc) begin
          e = q.pop_front();
          chk("out_vld", dvld, e.vld);
          chk("out_byte", dout, e.data);
          chk("lane_idx", lane_idx, e.lane);
        end else begin
          if (q.size() > 0 && q[0].stamp < cyc) begin
            chk("missed_slot", q[0].stamp, cyc);
            void'(q.pop_front());
          end
          chk("idle_vld", dvld, 1'b0);
        end
        chk("overflow", ovf, exp_ovf);
      end
    end
  end

  initial begin : driver
    logic [3:0][7:0] w;
    logic [3:0]      v;
    // Reset held 2 cycles with the strobe high.
    step(1'b1, 32'hD3C2B1A0, 4'hF, 1'b1);
    step(1'b1, 32'hD3C2B1A0, 4'hF, 1'b1);
    @(posedge clk); #1;
    chk("rst_out", dout, 8'h00);
    chk("rst_vld", dvld, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    mon_en = 1'b1;

    // Single word, all lanes valid.
    step(1'b1, 32'hD3C2B1A0, 4'hF, 1'b0);
    idle(6);

    // Back-to-back words at the full 4-cycle rate.
    for (int k = 0; k < 3; k++) begin
      w = {8'(8'h40 + k), 8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k)};
      step(1'b1, w, 4'hF, 1'b0);
      idle(3);
    end
    idle(3);

    // Lane valids 1,0,1,0.
    step(1'b1, 32'h44332211, 4'b0101, 1'b0);
    idle(5);

    // All-invalid word.
    step(1'b1, 32'h01020304, 4'b0000, 1'b0);
    idle(5);

    // Second word two cycles after the first is dropped.
    step(1'b1, 32'h8C8B8A89, 4'hF, 1'b0);
    idle(1);
    step(1'b1, 32'hEEEEEEEE, 4'hF, 1'b0);
    idle(5);

    // Reset after two bytes of a word have been emitted.
    step(1'b1, 32'h5A5B5C5D, 4'hF, 1'b0);
    idle(2);
    step(1'b0, '0, '0, 1'b1);
    idle(6);

    // Random stream with occasional resets.
    for (int k = 0; k < 400; k++) begin
      w = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      v = 4'($urandom);
      if ($urandom_range(99) < 2) step(1'b0, w, v, 1'b1);
      else step($urandom_range(99) < 45, w, v, 1'b0);
    end

    idle(8);
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
